// File: rtl/note_matrix_scan.sv
// note_matrix_scan: renders the 10-slot scrolling note window onto a
// column-multiplexed 8-row red/blue LED matrix. The note inputs and the
// scroll offset are captured once per frame, so the picture never tears.
// After a song-end pulse the rows are blanked for CLEAR_FRAMES frames.
// The columns keep scanning while the display is blanked.
module note_matrix_scan #(
    parameter int COLS         = 16,
    parameter int DWELL        = 1000,
    parameter int BLANK        = 8,
    parameter int NOTE_W       = 4,
    parameter int CLEAR_FRAMES = 4,
    parameter int HIT_COL      = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [9:0]      note_R,
    input  logic [9:0]      note_B,
    input  logic [3:0]      offset,
    input  logic            finish,
    output logic [COLS-1:0] col_en,
    output logic [7:0]      row_R,
    output logic [7:0]      row_B,
    output logic            frame_sync,
    output logic            clearing
);

    localparam int MAX_CNT = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int CLR_W   = (CLEAR_FRAMES > 0) ? $clog2(CLEAR_FRAMES + 1) : 1;

    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] HIT       = COL_W'(HIT_COL);
    localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK - 1);
    localparam logic [CLR_W-1:0] CLR_INIT  = CLR_W'(CLEAR_FRAMES);
    localparam logic [3:0]       NOTE_W_L  = 4'(NOTE_W);
    localparam logic [COLS-1:0]  COL_ONE   = COLS'(1);

    typedef enum logic [1:0] {
        LATCH = 2'd0,
        ON    = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [9:0]        noteR_q, noteR_d;
    logic [9:0]        noteB_q, noteB_d;
    logic [2:0]        phase_q, phase_d;
    logic [7:0]        slot_q, slot_d;
    logic              finishSeen_q, finishSeen_d;
    logic [CLR_W-1:0]  clearCnt_q, clearCnt_d;
    logic [COLS-1:0]   colEn_q, colEn_d;
    logic [7:0]        rowR_q, rowR_d;
    logic [7:0]        rowB_q, rowB_d;
    logic              frameSync_q, frameSync_d;
    logic              clearing_q, clearing_d;
    logic              doLatch;
    logic              enterOn;

    // State register: reset parks in LATCH with frameSync low, which makes
    // the first edge after reset perform the frame latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LATCH;
            col_q        <= '0;
            cnt_q        <= '0;
            noteR_q      <= '0;
            noteB_q      <= '0;
            phase_q      <= '0;
            slot_q       <= '0;
            finishSeen_q <= 1'b0;
            clearCnt_q   <= '0;
            colEn_q      <= '0;
            rowR_q       <= '0;
            rowB_q       <= '0;
            frameSync_q  <= 1'b0;
            clearing_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            cnt_q        <= cnt_d;
            noteR_q      <= noteR_d;
            noteB_q      <= noteB_d;
            phase_q      <= phase_d;
            slot_q       <= slot_d;
            finishSeen_q <= finishSeen_d;
            clearCnt_q   <= clearCnt_d;
            colEn_q      <= colEn_d;
            rowR_q       <= rowR_d;
            rowB_q       <= rowB_d;
            frameSync_q  <= frameSync_d;
            clearing_q   <= clearing_d;
        end
    end

    // Next state and next output values. The outputs are computed for the
    // state being entered. Slot and phase advance incrementally, so no divider is needed.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        cnt_d        = cnt_q;
        noteR_d      = noteR_q;
        noteB_d      = noteB_q;
        phase_d      = phase_q;
        slot_d       = slot_q;
        finishSeen_d = finishSeen_q | finish;
        clearCnt_d   = clearCnt_q;
        colEn_d      = '0;
        rowR_d       = '0;
        rowB_d       = '0;
        frameSync_d  = 1'b0;
        clearing_d   = 1'b0;
        doLatch      = 1'b0;
        enterOn      = 1'b0;

        case (state_q)
            LATCH: begin
                if (frameSync_q) begin
                    state_d = ON;
                    col_d   = '0;
                    cnt_d   = '0;
                    enterOn = 1'b1;
                end else begin
                    doLatch = 1'b1;
                end
            end
            ON: begin
                if (cnt_q == DWELL_END) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    colEn_d = colEn_q;
                    rowR_d  = rowR_q;
                    rowB_d  = rowB_q;
                end
            end
            GAP: begin
                if (cnt_q == BLANK_END) begin
                    cnt_d = '0;
                    if (col_q == LAST_COL) begin
                        doLatch = 1'b1;
                    end else begin
                        state_d = ON;
                        col_d   = col_q + COL_W'(1);
                        enterOn = 1'b1;
                        if (phase_q == 3'd6) begin
                            phase_d = 3'd0;
                            slot_d  = slot_q + 8'd1;
                        end else begin
                            phase_d = phase_q + 3'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LATCH;
            end
        endcase

        if (doLatch) begin
            state_d     = LATCH;
            col_d       = '0;
            frameSync_d = 1'b1;
            noteR_d     = note_R;
            noteB_d     = note_B;
            phase_d     = (offset > 4'd6) ? 3'd6 : offset[2:0];
            slot_d      = 8'd0;
            if (finishSeen_q) begin
                clearCnt_d   = CLR_INIT;
                finishSeen_d = finish;
            end else if (clearCnt_q != '0) begin
                clearCnt_d = clearCnt_q - CLR_W'(1);
            end
        end

        if (enterOn) begin
            colEn_d = COL_ONE << col_d;
            if (({1'b0, phase_d} < NOTE_W_L) && (slot_d <= 8'd9)) begin
                if (noteR_q[slot_d[3:0]]) begin
                    rowR_d = rowR_d | 8'h3C;
                end
                if (noteB_q[slot_d[3:0]]) begin
                    rowB_d = rowB_d | 8'h3C;
                end
            end
            if (col_d == HIT) begin
                rowR_d = rowR_d | 8'h81;
                rowB_d = rowB_d | 8'h81;
            end
            if (clearCnt_q != '0) begin
                rowR_d = 8'h00;
                rowB_d = 8'h00;
            end
        end

        clearing_d = (clearCnt_d != '0);
    end

    assign col_en     = colEn_q;
    assign row_R      = rowR_q;
    assign row_B      = rowB_q;
    assign frame_sync = frameSync_q;
    assign clearing   = clearing_q;

endmodule

// File: tb/tb_note_matrix_scan.sv
// tb_note_matrix_scan: directed scenarios for note_matrix_scan using a small
// configuration (16 columns, 4-cycle dwell, 2-cycle gap, 97-cycle frame).
module tb_note_matrix_scan;

    logic        clk;
    logic        rst;
    logic [9:0]  note_R;
    logic [9:0]  note_B;
    logic [3:0]  offset;
    logic        finish;
    logic [15:0] col_en;
    logic [7:0]  row_R;
    logic [7:0]  row_B;
    logic        frame_sync;
    logic        clearing;

    int testsRun;
    int testsFailed;

    logic [15:0] capEn  [16];
    logic [7:0]  capR   [16];
    logic [7:0]  capB   [16];
    logic        capClr [16];

    note_matrix_scan #(
        .COLS(16), .DWELL(4), .BLANK(2), .NOTE_W(4), .CLEAR_FRAMES(4), .HIT_COL(0)
    ) dut (
        .clk(clk), .rst(rst), .note_R(note_R), .note_B(note_B), .offset(offset),
        .finish(finish), .col_en(col_en), .row_R(row_R), .row_B(row_B),
        .frame_sync(frame_sync), .clearing(clearing)
    );

    // 10 ns free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pixel for one column: slot/phase by plain division
    function automatic logic [7:0] expRow(input logic [9:0] notes, input int off,
                                          input int col, input bit clr);
        int o, p, slot, ph;
        logic [7:0] r;
        o    = (off > 6) ? 6 : off;
        p    = col + o;
        slot = p / 7;
        ph   = p % 7;
        r    = 8'h00;
        if (ph < 4 && slot <= 9) begin
            if (notes[slot]) r = r | 8'h3C;
        end
        if (col == 0) r = r | 8'h81;
        if (clr) r = 8'h00;
        return r;
    endfunction

    // Waits (bounded) for the next frame_sync pulse, sampled on negedge
    task automatic syncToFrame(output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_sync === 1'b1) begin
                found = 1'b1;
                return;
            end
        end
    endtask

    // Records the first ON cycle of each column of the frame that has just
    // synced; optionally rewrites note_R while column changeCol is lit
    task automatic captureFrame(input int changeCol, input logic [9:0] newR);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            capEn[c]  = col_en;
            capR[c]   = row_R;
            capB[c]   = row_B;
            capClr[c] = clearing;
            if (c == changeCol) note_R = newR;
            repeat (5) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        bit found;
        int n;
        rst = 1'b1; note_R = '0; note_B = '0; offset = '0; finish = 1'b0;
        repeat (3) @(negedge clk);
        testsRun++;
        if (col_en !== 16'h0 || row_R !== 8'h0 || row_B !== 8'h0 ||
            frame_sync !== 1'b0 || clearing !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got col_en=%h rows=%h/%h fs=%b clr=%b, want all 0",
                     col_en, row_R, row_B, frame_sync, clearing);
        end
        rst = 1'b0;
        @(negedge clk);
        testsRun++;
        if (frame_sync !== 1'b1 || col_en !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL first_latch: got fs=%b col_en=%h, want fs=1 col_en=0000",
                     frame_sync, col_en);
        end
        for (int i = 0; i < 7; i++) begin
            logic [15:0] want;
            @(negedge clk);
            want = (i < 4) ? 16'h0001 : ((i < 6) ? 16'h0000 : 16'h0002);
            testsRun++;
            if (col_en !== want || frame_sync !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL scan_cycle%0d: got col_en=%h fs=%b, want col_en=%h fs=0",
                         i, col_en, frame_sync, want);
            end
        end
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (frame_sync === 1'b1) break;
        end
        testsRun++;
        if (n !== 90) begin
            testsFailed++;
            $display("[TB] FAIL frame_period: got next sync after %0d cycles, want 90", n);
        end
        syncToFrame(found);
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL idle_sync: got no frame_sync, want one");
        end
        captureFrame(-1, 10'h0);
        for (int c = 0; c < 16; c++) begin
            logic [15:0] wantEn;
            logic [7:0]  wantRow;
            wantEn  = 16'h0001 << c;
            wantRow = expRow(10'h0, 0, c, 1'b0);
            testsRun++;
            if (capEn[c] !== wantEn || capR[c] !== wantRow || capB[c] !== wantRow) begin
                testsFailed++;
                $display("[TB] FAIL idle_col%0d: got en=%h R=%h B=%h, want en=%h R=%h B=%h",
                         c, capEn[c], capR[c], capB[c], wantEn, wantRow, wantRow);
            end
        end
    endtask

    task automatic test_red_note;
        bit found;
        note_R = 10'h001; note_B = 10'h000; offset = 4'd0;
        syncToFrame(found);
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL red_sync: got no frame_sync, want one");
        end
        captureFrame(-1, 10'h0);
        for (int c = 0; c < 16; c++) begin
            logic [7:0] wantR, wantB;
            wantR = expRow(10'h001, 0, c, 1'b0);
            wantB = expRow(10'h000, 0, c, 1'b0);
            testsRun++;
            if (capEn[c] !== (16'h0001 << c) || capR[c] !== wantR || capB[c] !== wantB) begin
                testsFailed++;
                $display("[TB] FAIL red_col%0d: got en=%h R=%h B=%h, want R=%h B=%h",
                         c, capEn[c], capR[c], capB[c], wantR, wantB);
            end
        end
    endtask

    task automatic test_offset;
        bit found;
        int offs [2];
        offs[0] = 3;
        offs[1] = 9;
        for (int k = 0; k < 2; k++) begin
            note_R = 10'h000; note_B = 10'h002; offset = 4'(offs[k]);
            syncToFrame(found);
            testsRun++;
            if (!found) begin
                testsFailed++;
                $display("[TB] FAIL offset_sync%0d: got no frame_sync, want one", offs[k]);
            end
            captureFrame(-1, 10'h0);
            for (int c = 0; c < 16; c++) begin
                logic [7:0] wantR, wantB;
                wantR = expRow(10'h000, offs[k], c, 1'b0);
                wantB = expRow(10'h002, offs[k], c, 1'b0);
                testsRun++;
                if (capR[c] !== wantR || capB[c] !== wantB) begin
                    testsFailed++;
                    $display("[TB] FAIL offset%0d_col%0d: got R=%h B=%h, want R=%h B=%h",
                             offs[k], c, capR[c], capB[c], wantR, wantB);
                end
            end
        end
    endtask

    task automatic test_double_buffer;
        bit found;
        note_R = 10'h003; note_B = 10'h000; offset = 4'd0;
        syncToFrame(found);
        testsRun++;
        if (!found) begin
            testsFailed++;
            $display("[TB] FAIL dbuf_sync: got no frame_sync, want one");
        end
        captureFrame(5, 10'h000);
        for (int c = 0; c < 16; c++) begin
            logic [7:0] wantR;
            wantR = expRow(10'h003, 0, c, 1'b0);
            testsRun++;
            if (capR[c] !== wantR) begin
                testsFailed++;
                $display("[TB] FAIL dbuf_old_col%0d: got R=%h, want R=%h", c, capR[c], wantR);
            end
        end
        syncToFrame(found);
        captureFrame(-1, 10'h0);
        for (int c = 0; c < 16; c++) begin
            logic [7:0] wantR;
            wantR = expRow(10'h000, 0, c, 1'b0);
            testsRun++;
            if (capR[c] !== wantR) begin
                testsFailed++;
                $display("[TB] FAIL dbuf_new_col%0d: got R=%h, want R=%h", c, capR[c], wantR);
            end
        end
    endtask

    task automatic test_finish_clear;
        bit found;
        note_R = 10'h001; note_B = 10'h001; offset = 4'd0;
        syncToFrame(found);
        repeat (20) @(negedge clk);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        syncToFrame(found);
        testsRun++;
        if (!found || clearing !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL clear_start: got sync=%b clearing=%b, want 1/1", found, clearing);
        end
        for (int f = 0; f < 4; f++) begin
            if (f > 0) begin
                @(negedge clk);
                testsRun++;
                if (frame_sync !== 1'b1 || clearing !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL clear_frame%0d_sync: got fs=%b clearing=%b, want 1/1",
                             f, frame_sync, clearing);
                end
            end
            captureFrame(-1, 10'h0);
            for (int c = 0; c < 16; c++) begin
                testsRun++;
                if (capEn[c] !== (16'h0001 << c) || capR[c] !== 8'h00 ||
                    capB[c] !== 8'h00 || capClr[c] !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL clear_frame%0d_col%0d: got en=%h R=%h B=%h clr=%b, want R=00 B=00 clr=1",
                             f, c, capEn[c], capR[c], capB[c], capClr[c]);
                end
            end
        end
        @(negedge clk);
        testsRun++;
        if (frame_sync !== 1'b1 || clearing !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clear_end: got fs=%b clearing=%b, want 1/0", frame_sync, clearing);
        end
        captureFrame(-1, 10'h0);
        for (int c = 0; c < 16; c++) begin
            logic [7:0] want;
            want = expRow(10'h001, 0, c, 1'b0);
            testsRun++;
            if (capR[c] !== want || capB[c] !== want || capClr[c] !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL after_clear_col%0d: got R=%h B=%h clr=%b, want R=%h B=%h clr=0",
                         c, capR[c], capB[c], capClr[c], want, want);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        bit found;
        note_R = 10'h001; note_B = 10'h000; offset = 4'd0;
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        syncToFrame(found);
        testsRun++;
        if (!found || clearing !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_pre_clear: got sync=%b clearing=%b, want 1/1", found, clearing);
        end
        repeat (55) @(negedge clk);
        testsRun++;
        if (col_en !== 16'h0200) begin
            testsFailed++;
            $display("[TB] FAIL rst_col9: got col_en=%h, want 0200", col_en);
        end
        #2 rst = 1'b1;
        #1;
        testsRun++;
        if (col_en !== 16'h0 || row_R !== 8'h0 || row_B !== 8'h0 ||
            frame_sync !== 1'b0 || clearing !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rst_async: got col_en=%h rows=%h/%h fs=%b clr=%b, want all 0",
                     col_en, row_R, row_B, frame_sync, clearing);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        testsRun++;
        if (frame_sync !== 1'b1 || clearing !== 1'b0 || col_en !== 16'h0) begin
            testsFailed++;
            $display("[TB] FAIL rst_relatch: got fs=%b clr=%b col_en=%h, want 1/0/0000",
                     frame_sync, clearing, col_en);
        end
        @(negedge clk);
        testsRun++;
        if (col_en !== 16'h0001 || row_R !== 8'hBD || row_B !== 8'h81) begin
            testsFailed++;
            $display("[TB] FAIL rst_col0: got col_en=%h R=%h B=%h, want 0001 BD 81",
                     col_en, row_R, row_B);
        end
    endtask

    // Runs every scenario in order, then reports
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst    = 1'b1;
        note_R = '0;
        note_B = '0;
        offset = '0;
        finish = 1'b0;
        test_reset();
        test_red_note();
        test_offset();
        test_double_buffer();
        test_finish_clear();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Hard stop if the run ever stalls
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
